// File: rtl/tmds_island_encoder.sv
// TMDS lane encoder: DVI 8b/10b video, control codes and HDMI data-island periods.
// Define TMDS_DATA_ISLAND_EN for preambles, guard bands and TERC4 islands (else DVI only).
module tmds_island_encoder #(
  parameter string CHANNEL      = "BLUE",
  parameter int    ISLAND_START = 752,
  parameter int    ISLAND_LEN   = 64,
  parameter int    VGUARD_X     = 856,
  parameter int    V_ACTIVE     = 480,
  parameter int    V_TOTAL      = 525
) (
  input  logic        clkin,
  input  logic        rstin,
  input  logic [7:0]  din,
  input  logic        c0,
  input  logic        c1,
  input  logic [11:0] counterX,
  input  logic [11:0] counterY,
  input  logic        de,
  input  logic        iDataD0,
  input  logic        iDataD1,
  input  logic        iDataD2,
  input  logic        iDataD3,
  output logic [9:0]  dout
);

`ifdef TMDS_DATA_ISLAND_EN
  localparam bit ISL_EN = 1'b1;
`else
  localparam bit ISL_EN = 1'b0;
`endif

  localparam bit IS_BLUE  = (CHANNEL == "BLUE");
  localparam bit IS_GREEN = (CHANNEL == "GREEN");

  localparam logic [9:0] CTL0  = 10'b1101010100;
  localparam logic [9:0] CTL1  = 10'b0010101011;
  localparam logic [9:0] GRD_A = 10'b0100110011;
  localparam logic [9:0] GRD_B = 10'b1011001100;

  localparam logic [11:0] IPRE_LO = 12'(ISLAND_START - 10);
  localparam logic [11:0] IPRE_HI = 12'(ISLAND_START - 3);
  localparam logic [11:0] LGRD_LO = 12'(ISLAND_START - 2);
  localparam logic [11:0] LGRD_HI = 12'(ISLAND_START - 1);
  localparam logic [11:0] ISL_LO  = 12'(ISLAND_START);
  localparam logic [11:0] ISL_HI  = 12'(ISLAND_START + ISLAND_LEN - 1);
  localparam logic [11:0] TGRD_LO = 12'(ISLAND_START + ISLAND_LEN);
  localparam logic [11:0] TGRD_HI = 12'(ISLAND_START + ISLAND_LEN + 1);
  localparam logic [11:0] VPRE_LO = 12'(VGUARD_X - 8);
  localparam logic [11:0] VPRE_HI = 12'(VGUARD_X - 1);
  localparam logic [11:0] VGRD_LO = 12'(VGUARD_X);
  localparam logic [11:0] VGRD_HI = 12'(VGUARD_X + 1);
  localparam logic [11:0] VACT_M1 = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VTOT_M1 = 12'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    P_CTL, P_VPRE, P_VGRD, P_IPRE, P_IGRD, P_ISL, P_VID
  } period_t;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    case (c)
      2'b00:   ctl_code = 10'b1101010100;
      2'b01:   ctl_code = 10'b0010101011;
      2'b10:   ctl_code = 10'b0101010100;
      default: ctl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] v);
    case (v)
      4'h0:    terc4 = 10'b1010011100;
      4'h1:    terc4 = 10'b1001100011;
      4'h2:    terc4 = 10'b1011100100;
      4'h3:    terc4 = 10'b1011100010;
      4'h4:    terc4 = 10'b0101110001;
      4'h5:    terc4 = 10'b0100011110;
      4'h6:    terc4 = 10'b0110001110;
      4'h7:    terc4 = 10'b0100111100;
      4'h8:    terc4 = 10'b1011001100;
      4'h9:    terc4 = 10'b0100111001;
      4'hA:    terc4 = 10'b0110011100;
      4'hB:    terc4 = 10'b1011000110;
      4'hC:    terc4 = 10'b1010001110;
      4'hD:    terc4 = 10'b1001110001;
      4'hE:    terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  logic [9:0]        dout_q, dout_d;
  logic signed [4:0] disp_q, disp_d;
  period_t           period;

  logic in_ipre, in_igrd, in_isl, vline, in_vpre, in_vgrd;

  always_comb begin
    in_isl  = counterX >= ISL_LO && counterX <= ISL_HI;
    in_igrd = (counterX >= LGRD_LO && counterX <= LGRD_HI)
           || (counterX >= TGRD_LO && counterX <= TGRD_HI);
    in_ipre = counterX >= IPRE_LO && counterX <= IPRE_HI;
    vline   = counterY < VACT_M1 || counterY == VTOT_M1;
    in_vgrd = vline && counterX >= VGRD_LO && counterX <= VGRD_HI;
    in_vpre = vline && counterX >= VPRE_LO && counterX <= VPRE_HI;
  end

  always_comb begin
    period = P_CTL;
    if (de)                      period = P_VID;
    else if (ISL_EN && in_isl)   period = P_ISL;
    else if (ISL_EN && in_igrd)  period = P_IGRD;
    else if (ISL_EN && in_ipre)  period = P_IPRE;
    else if (ISL_EN && in_vgrd)  period = P_VGRD;
    else if (ISL_EN && in_vpre)  period = P_VPRE;
  end

  logic [3:0]        n1d, n1q;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic signed [4:0] bal, disp_v;
  logic [9:0]        vid;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, din[i]};
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !din[0]);
    q_m[0] = din[0];
    for (int i = 1; i < 8; i++) q_m[i] = q_m[i-1] ^ din[i] ^ use_xnor;
    q_m[8] = !use_xnor;
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q_m[i]};
    // bal = ones - zeros of q_m[7:0]
    bal = {n1q, 1'b0} - 5'd8;
    if (disp_q == 5'sd0 || bal == 5'sd0) begin
      vid    = {!q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      disp_v = q_m[8] ? disp_q + bal : disp_q - bal;
    end else if (disp_q[4] == bal[4]) begin
      vid    = {1'b1, q_m[8], ~q_m[7:0]};
      disp_v = disp_q + {3'b000, q_m[8], 1'b0} - bal;
    end else begin
      vid    = {1'b0, q_m[8], q_m[7:0]};
      disp_v = disp_q - {3'b000, !q_m[8], 1'b0} + bal;
    end
  end

  always_comb begin
    dout_d = CTL0;
    disp_d = '0;
    unique case (period)
      P_VID: begin
        dout_d = vid;
        disp_d = disp_v;
      end
      P_ISL:  dout_d = terc4({iDataD3, iDataD2, iDataD1, iDataD0});
      P_IGRD: dout_d = IS_BLUE ? terc4({2'b11, c1, c0}) : GRD_A;
      P_IPRE: dout_d = IS_BLUE ? ctl_code({c1, c0}) : CTL1;
      P_VGRD: dout_d = IS_GREEN ? GRD_A : GRD_B;
      P_VPRE: dout_d = IS_BLUE ? ctl_code({c1, c0}) : (IS_GREEN ? CTL1 : CTL0);
      default: dout_d = (IS_BLUE || !ISL_EN) ? ctl_code({c1, c0}) : CTL0;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rstin) begin
      dout_q <= CTL0;
      disp_q <= '0;
    end else begin
      dout_q <= dout_d;
      disp_q <= disp_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_tmds_island_encoder.sv
// Scoreboard bench for tmds_island_encoder: all three lanes share one stimulus stream.
// Expected characters come from a period/table model and a disparity-counting video model.
`timescale 1ns/1ps
module tb_tmds_island_encoder;

`ifdef TMDS_DATA_ISLAND_EN
  localparam bit ISL = 1'b1;
`else
  localparam bit ISL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, c0, c1, de;
  logic [7:0]  din;
  logic [11:0] cx, cy;
  logic [3:0]  d;
  logic [9:0]  dout_b, dout_g, dout_r;

  tmds_island_encoder #(.CHANNEL("BLUE")) u_b (
    .clkin(clk), .rstin(rst_n), .din(din), .c0(c0), .c1(c1),
    .counterX(cx), .counterY(cy), .de(de),
    .iDataD0(d[0]), .iDataD1(d[1]), .iDataD2(d[2]), .iDataD3(d[3]),
    .dout(dout_b));
  tmds_island_encoder #(.CHANNEL("GREEN")) u_g (
    .clkin(clk), .rstin(rst_n), .din(din), .c0(c0), .c1(c1),
    .counterX(cx), .counterY(cy), .de(de),
    .iDataD0(d[0]), .iDataD1(d[1]), .iDataD2(d[2]), .iDataD3(d[3]),
    .dout(dout_g));
  tmds_island_encoder #(.CHANNEL("RED")) u_r (
    .clkin(clk), .rstin(rst_n), .din(din), .c0(c0), .c1(c1),
    .counterX(cx), .counterY(cy), .de(de),
    .iDataD0(d[0]), .iDataD1(d[1]), .iDataD2(d[2]), .iDataD3(d[3]),
    .dout(dout_r));

  localparam logic [9:0] CTL [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] GRD_A = 10'b0100110011;
  localparam logic [9:0] GRD_B = 10'b1011001100;

  typedef struct {
    logic [2:0][9:0] e;
    string           tag;
  } exp_t;

  exp_t sbq[$];
  int   disp [3];
  int   checks = 0;
  int   failures = 0;

  function automatic int ones10(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  // q_m bit i is the parity of din[0..i]; XNOR mode flips every odd bit.
  task automatic vid_enc(input int l, output logic [9:0] code);
    int   n1, nq, par;
    bit   xn;
    logic [8:0] qm;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(din[i]);
    xn = (n1 > 4) || (n1 == 4 && din[0] == 1'b0);
    par = 0;
    for (int i = 0; i < 8; i++) begin
      par = par ^ int'(din[i]);
      qm[i] = (par[0] ^ (xn && (i % 2 == 1)));
    end
    qm[8] = !xn;
    nq = 0;
    for (int i = 0; i < 8; i++) nq += int'(qm[i]);
    if (disp[l] == 0 || nq == 4)
      code = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    else if ((disp[l] > 0) == (nq > 4))
      code = {1'b1, qm[8], ~qm[7:0]};
    else
      code = {1'b0, qm[8], qm[7:0]};
    disp[l] += 2 * ones10(code) - 10;
  endtask

  task automatic model(input int l, output logic [9:0] e);
    int x, y, s, ln, vg;
    bit vl;
    x  = int'(cx);
    y  = int'(cy);
    s  = 752;
    ln = 64;
    vg = 856;
    vl = (y < 479) || (y == 524);
    if (!rst_n) begin
      e = CTL[0];
      disp[l] = 0;
    end else if (de) begin
      vid_enc(l, e);
    end else begin
      disp[l] = 0;
      if (ISL && x >= s && x < s + ln)
        e = TERC[d];
      else if (ISL && (x == s-2 || x == s-1 || x == s+ln || x == s+ln+1))
        e = (l == 0) ? TERC[{2'b11, c1, c0}] : GRD_A;
      else if (ISL && x >= s-10 && x <= s-3)
        e = (l == 0) ? CTL[{c1, c0}] : CTL[1];
      else if (ISL && vl && (x == vg || x == vg+1))
        e = (l == 1) ? GRD_A : GRD_B;
      else if (ISL && vl && x >= vg-8 && x < vg)
        e = (l == 0) ? CTL[{c1, c0}] : ((l == 1) ? CTL[1] : CTL[0]);
      else
        e = (l == 0 || !ISL) ? CTL[{c1, c0}] : CTL[0];
    end
  endtask

  task automatic issue(input string tag);
    exp_t       t;
    logic [9:0] e;
    for (int l = 0; l < 3; l++) begin
      model(l, e);
      t.e[l] = e;
    end
    t.tag = tag;
    sbq.push_back(t);
    @(negedge clk);
  endtask

  always @(posedge clk) begin : monitor
    exp_t       t;
    logic [9:0] act;
    #1;
    if (sbq.size() > 0) begin
      t = sbq.pop_front();
      for (int l = 0; l < 3; l++) begin
        act = (l == 0) ? dout_b : ((l == 1) ? dout_g : dout_r);
        checks++;
        if (act !== t.e[l]) begin
          failures++;
          $display("FAIL %s lane=%0d got=%b exp=%b", t.tag, l, act, t.e[l]);
        end
      end
    end
  end

  int ys [4] = '{10, 479, 480, 524};

  initial begin
    rst_n = 1'b0; de = 1'b0; din = '0; c0 = 1'b0; c1 = 1'b0;
    cx = '0; cy = '0; d = '0;
    @(negedge clk);
    repeat (3) issue("reset");
    rst_n = 1'b1;
    repeat (3) issue("post_reset");

    cx = 12'd100; cy = 12'd5; de = 1'b1; din = 8'h00;
    repeat (12) issue("video_00");
    de = 1'b0;
    issue("video_off");
    for (int i = 0; i < 200; i++) begin
      din = 8'($urandom);
      de = ($urandom_range(0, 9) != 0);
      {c1, c0} = 2'($urandom);
      issue("video_rand");
    end

    de = 1'b0; cy = 12'd10; {c1, c0} = 2'b00;
    cx = 12'd752; d = 4'b0101;
    issue("blue_island_5");
    cx = 12'd750;
    issue("blue_guard_c");

    for (int x = 740; x <= 820; x++) begin
      cx = 12'(x);
      d = 4'($urandom);
      {c1, c0} = 2'($urandom);
      issue($sformatf("island_sweep x=%0d", x));
    end

    for (int k = 0; k < 4; k++) begin
      cy = 12'(ys[k]);
      for (int x = 845; x <= 860; x++) begin
        cx = 12'(x);
        {c1, c0} = 2'($urandom);
        issue($sformatf("vguard y=%0d x=%0d", ys[k], x));
      end
    end

    cy = 12'd10; cx = 12'd760; de = 1'b1;
    repeat (6) begin
      din = 8'($urandom);
      issue("de_in_island");
    end
    de = 1'b0;
    issue("de_fall_island");
    de = 1'b1; din = 8'h00;
    repeat (3) issue("de_rise_cleared");

    cx = 12'd200;
    repeat (5) begin
      din = 8'($urandom);
      issue("video_pre_rst");
    end
    rst_n = 1'b0;
    issue("rst_mid_video");
    rst_n = 1'b1;
    repeat (4) begin
      din = 8'($urandom);
      issue("video_post_rst");
    end

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      cx = 12'($urandom_range(735, 870));
      cy = 12'(ys[$urandom_range(0, 3)]);
      de = ($urandom_range(0, 4) == 0);
      din = 8'($urandom);
      d = 4'($urandom);
      {c1, c0} = 2'($urandom);
      issue($sformatf("mix x=%0d y=%0d", cx, cy));
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
